// File: rtl/axis_data_gen.sv
// -----------------------------------------------------------------------------
// axis_data_gen
//
// AXI-Stream test-pattern source behind an ap_ctrl_hs-style handshake. Each
// accepted start emits `size` beats carrying an incrementing counter
// (0, 1, ... size-1). The final beat carries tlast. ap_done pulses for one
// cycle after that beat has been accepted.
//
// Ports:
//   ap_clk    in   1      clock, rising edge
//   ap_rst_n  in   1      asynchronous active-low reset
//   size      in   32     beats per run, latched when a start is accepted
//   ap_start  in   1      start request (level), sampled only while idle
//   ap_done   out  1      one-cycle pulse after the final beat is accepted
//   ap_idle   out  1      high while idle
//   ap_ready  out  1      high in the cycle a start is accepted
//   tdata     out  WIDTH  stream data (beat index)
//   tvalid    out  1      stream valid
//   tlast     out  1      final beat of a run
//   tready    in   1      stream ready from the consumer
// -----------------------------------------------------------------------------
module axis_data_gen #(
    parameter int WIDTH = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      size,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    output logic             tlast,
    input  logic             tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] idx;
    logic [31:0] size_q;
    logic        last_beat;

    // size_q is never 0 while in RUN, so the subtraction cannot wrap there.
    assign last_beat = (idx == size_q - 32'd1);

    // NOTE: every register here is written with <= so all flops update from
    // the same pre-edge values; blocking assignments would create ordering
    // dependencies between the state, idx and size_q updates.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            size_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        size_q <= size;
                        idx    <= '0;
                        state  <= (size == 32'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Without acceptance idx holds, so tdata/tlast stay stable.
                    if (tready) begin
                        idx <= idx + 32'd1;
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state; only ap_ready also looks at ap_start.
    // tready never reaches an output combinationally.
    assign ap_idle  = (state == IDLE);
    assign ap_ready = (state == IDLE) && ap_start;
    assign ap_done  = (state == DONE);
    assign tvalid   = (state == RUN);
    assign tlast    = (state == RUN) && last_beat;

    generate
        if (WIDTH <= 32) begin : g_narrow
            assign tdata = idx[WIDTH-1:0];
        end else begin : g_wide
            assign tdata = {{(WIDTH-32){1'b0}}, idx};
        end
    endgenerate

endmodule

// File: tb/tb_axis_data_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_data_gen
//
// Self-checking bench for axis_data_gen. Inputs are driven on the falling edge
// and outputs are sampled just after it, well away from the rising edge.
// Expected values come from a run-level model: a run of S beats must deliver
// indices 0..S-1 in order, tlast only on S-1, then one ap_done cycle, then idle.
// -----------------------------------------------------------------------------
module tb_axis_data_gen;

    localparam int WIDTH = 32;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic [31:0]      size;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    int checks   = 0;
    int failures = 0;

    axis_data_gen #(.WIDTH(WIDTH)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .size     (size),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .tdata    (tdata),
        .tvalid   (tvalid),
        .tlast    (tlast),
        .tready   (tready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge with the DUT idle. Performs one run of
    // s beats. rand_ready throttles tready randomly; hold_start leaves ap_start
    // high so the next run is requested back-to-back. size is scribbled with
    // random values during the run to show only the latched value matters.
    task automatic do_run(input int unsigned s, input bit hold_start, input bit rand_ready);
        longint unsigned k;
        int              cycles;
        bit              accepted;
        size     = s;
        ap_start = 1'b1;
        #1;
        chk("start_ready", ap_ready, 1'b1);
        chk("start_idle",  ap_idle,  1'b1);
        chk("start_valid", tvalid,   1'b0);
        @(negedge ap_clk);
        if (!hold_start) ap_start = 1'b0;

        k      = 0;
        cycles = 0;
        while (k < s && cycles < 64 + 8 * s) begin
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            size   = $urandom;
            #1;
            chk("run_valid", tvalid, 1'b1);
            chk("run_data",  {32'd0, tdata}, k);
            chk("run_last",  tlast, (k == s - 1));
            chk("run_done",  ap_done, 1'b0);
            chk("run_idle",  ap_idle, 1'b0);
            accepted = tready;
            @(negedge ap_clk);
            if (accepted) k++;
            cycles++;
        end
        if (k != s) chk("run_timeout", k, s);

        #1;
        chk("done_pulse", ap_done, 1'b1);
        chk("done_valid", tvalid,  1'b0);
        chk("done_last",  tlast,   1'b0);
        chk("done_idle",  ap_idle, 1'b0);
        @(negedge ap_clk);
        #1;
        chk("post_idle",  ap_idle,  1'b1);
        chk("post_done",  ap_done,  1'b0);
        chk("post_ready", ap_ready, hold_start);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        size     = '0;
        ap_start = 1'b0;
        tready   = 1'b0;
        #1;
        chk("rst_idle",  ap_idle,  1'b1);
        chk("rst_done",  ap_done,  1'b0);
        chk("rst_ready", ap_ready, 1'b0);
        chk("rst_valid", tvalid,   1'b0);
        chk("rst_last",  tlast,    1'b0);
        chk("rst_data",  tdata,    '0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Basic run, continuous ready.
        do_run(4, 1'b0, 1'b0);
        @(negedge ap_clk);

        // Back-pressure, then a few random sizes under random ready.
        do_run(5, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            do_run($urandom_range(1, 12), 1'b0, 1'b1);
        end

        // Zero size: done next cycle, no beats.
        do_run(0, 1'b0, 1'b0);

        // Single-beat run: first beat is also the last.
        do_run(1, 1'b0, 1'b1);

        // Start held high: runs repeat back-to-back from 0.
        for (int r = 0; r < 3; r++) begin
            do_run(3, 1'b1, 1'b0);
        end
        ap_start = 1'b0;
        @(negedge ap_clk);
        #1;
        chk("hold_end_idle", ap_idle, 1'b1);

        // Reset mid-run after beats 0..2 have been accepted.
        @(negedge ap_clk);
        size     = 8;
        ap_start = 1'b1;
        tready   = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("pre_abort_data", tdata, 32'd3);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("abort_valid", tvalid,  1'b0);
        chk("abort_idle",  ap_idle, 1'b1);
        chk("abort_last",  tlast,   1'b0);
        chk("abort_data",  tdata,   '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            #1;
            chk("abort_no_done", ap_done, 1'b0);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        do_run(8, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
